// File: rtl/conv_seq_ctrl.sv
// Sequencer for a KxK, stride-1, no-padding 2D convolution: walks every output pixel,
// issues image/coefficient reads and aligned MAC strobes, then hands each result off.
module conv_seq_ctrl #(
    parameter int unsigned IMG_W   = 8,
    parameter int unsigned IMG_H   = 8,
    parameter int unsigned K       = 3,
    parameter int unsigned ADDR_W  = 6,
    parameter int unsigned CADDR_W = 4,
    parameter int unsigned OADDR_W = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    output logic               busy,
    output logic               done,
    output logic               rd_en,
    output logic [ADDR_W-1:0]  img_addr,
    output logic [CADDR_W-1:0] coef_addr,
    output logic               mac_en,
    output logic               mac_first,
    output logic               mac_last,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [OADDR_W-1:0] out_addr
);

    localparam int unsigned OW = IMG_W - K + 1;
    localparam int unsigned OH = IMG_H - K + 1;
    localparam int unsigned KW = (K > 1) ? $clog2(K) : 1;
    localparam int unsigned XW = (OW > 1) ? $clog2(OW) : 1;
    localparam int unsigned YW = (OH > 1) ? $clog2(OH) : 1;

    localparam logic [2:0] StIdle  = 3'd0;
    localparam logic [2:0] StMac   = 3'd1;
    localparam logic [2:0] StDrain = 3'd2;
    localparam logic [2:0] StWrite = 3'd3;
    localparam logic [2:0] StDone  = 3'd4;

    logic [2:0]    state_q, state_d;
    logic [KW-1:0] kx_q, kx_d, ky_q, ky_d;
    logic [XW-1:0] ox_q, ox_d;
    logic [YW-1:0] oy_q, oy_d;
    logic          mac_en_q, mac_first_q, mac_last_q;

    logic kx_last, ky_last, ox_last, oy_last;
    logic tap_first, tap_last;

    assign kx_last   = (kx_q == KW'(K - 1));
    assign ky_last   = (ky_q == KW'(K - 1));
    assign ox_last   = (ox_q == XW'(OW - 1));
    assign oy_last   = (oy_q == YW'(OH - 1));
    assign tap_first = (kx_q == '0) && (ky_q == '0);
    assign tap_last  = kx_last && ky_last;

    always_comb begin
        state_d = state_q;
        kx_d    = kx_q;
        ky_d    = ky_q;
        ox_d    = ox_q;
        oy_d    = oy_q;
        case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StMac;
                end
            end
            StMac: begin
                if (kx_last) begin
                    kx_d = '0;
                    if (ky_last) begin
                        ky_d    = '0;
                        state_d = StDrain;
                    end else begin
                        ky_d = ky_q + 1'b1;
                    end
                end else begin
                    kx_d = kx_q + 1'b1;
                end
            end
            StDrain: state_d = StWrite;
            StWrite: begin
                if (out_ready) begin
                    kx_d = '0;
                    ky_d = '0;
                    if (ox_last) begin
                        ox_d = '0;
                        if (oy_last) begin
                            oy_d    = '0;
                            state_d = StDone;
                        end else begin
                            oy_d    = oy_q + 1'b1;
                            state_d = StMac;
                        end
                    end else begin
                        ox_d    = ox_q + 1'b1;
                        state_d = StMac;
                    end
                end
            end
            StDone: begin
                kx_d    = '0;
                ky_d    = '0;
                ox_d    = '0;
                oy_d    = '0;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            kx_q        <= '0;
            ky_q        <= '0;
            ox_q        <= '0;
            oy_q        <= '0;
            mac_en_q    <= 1'b0;
            mac_first_q <= 1'b0;
            mac_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            kx_q        <= kx_d;
            ky_q        <= ky_d;
            ox_q        <= ox_d;
            oy_q        <= oy_d;
            // One-cycle delay matches the read latency of the image/coef memories.
            mac_en_q    <= rd_en;
            mac_first_q <= rd_en && tap_first;
            mac_last_q  <= rd_en && tap_last;
        end
    end

    logic [ADDR_W-1:0] row, col;

    always_comb begin
        row       = ADDR_W'(oy_q) + ADDR_W'(ky_q);
        col       = ADDR_W'(ox_q) + ADDR_W'(kx_q);
        img_addr  = row * ADDR_W'(IMG_W) + col;
        coef_addr = CADDR_W'(ky_q) * CADDR_W'(K) + CADDR_W'(kx_q);
        out_addr  = OADDR_W'(oy_q) * OADDR_W'(OW) + OADDR_W'(ox_q);
    end

    assign rd_en     = (state_q == StMac);
    assign busy      = (state_q == StMac) || (state_q == StDrain) || (state_q == StWrite);
    assign done      = (state_q == StDone);
    assign out_valid = (state_q == StWrite);
    assign mac_en    = mac_en_q;
    assign mac_first = mac_first_q;
    assign mac_last  = mac_last_q;

endmodule

// File: tb/tb_conv_seq_ctrl.sv
// Bench for conv_seq_ctrl: a per-output tap-phase model checked every cycle on two
// configurations (8x8/K=3 and 4x4/K=1), plus literal timing/address expectations.
module tb_conv_seq_ctrl;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // Configuration A: defaults
    logic       start, out_ready;
    logic       busy, done, rd_en, mac_en, mac_first, mac_last, out_valid;
    logic [5:0] img_addr, out_addr;
    logic [3:0] coef_addr;

    // Configuration B: 4x4 image, K=1
    logic       start2, out_ready2;
    logic       busy2, done2, rd_en2, mac_en2, mac_first2, mac_last2, out_valid2;
    logic [3:0] img_addr2, out_addr2;
    logic [0:0] coef_addr2;

    conv_seq_ctrl u_dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .rd_en     (rd_en),
        .img_addr  (img_addr),
        .coef_addr (coef_addr),
        .mac_en    (mac_en),
        .mac_first (mac_first),
        .mac_last  (mac_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_addr  (out_addr)
    );

    conv_seq_ctrl #(
        .IMG_W   (4),
        .IMG_H   (4),
        .K       (1),
        .ADDR_W  (4),
        .CADDR_W (1),
        .OADDR_W (4)
    ) u_dut2 (
        .clk       (clk),
        .rst       (rst),
        .start     (start2),
        .busy      (busy2),
        .done      (done2),
        .rd_en     (rd_en2),
        .img_addr  (img_addr2),
        .coef_addr (coef_addr2),
        .mac_en    (mac_en2),
        .mac_first (mac_first2),
        .mac_last  (mac_last2),
        .out_valid (out_valid2),
        .out_ready (out_ready2),
        .out_addr  (out_addr2)
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(string name, int act, int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // Model: n = output index, p = phase within an output
    // (0..K*K-1 taps, K*K drain, K*K+1 write).
    typedef struct {
        bit act;
        bit dn;
        int n;
        int p;
    } mst_t;

    typedef struct {
        bit busy, done, rd_en, mac_en, mac_first, mac_last, out_valid, chk_addr;
        int img_addr, coef_addr, out_addr;
    } exp_t;

    function automatic mst_t step(mst_t s, int k, int npix, logic st, logic rdy);
        mst_t r = s;
        if (s.dn) begin
            r.dn = 1'b0;
        end else if (!s.act) begin
            if (st === 1'b1) begin
                r.act = 1'b1;
                r.n   = 0;
                r.p   = 0;
            end
        end else if (s.p <= k * k) begin
            r.p = s.p + 1;
        end else if (rdy === 1'b1) begin
            if (s.n == npix - 1) begin
                r.act = 1'b0;
                r.dn  = 1'b1;
                r.n   = 0;
            end else begin
                r.n = s.n + 1;
            end
            r.p = 0;
        end
        return r;
    endfunction

    function automatic exp_t model_out(int w, int k, int ow, mst_t s);
        exp_t e;
        e.busy      = s.act;
        e.done      = s.dn;
        e.rd_en     = s.act && (s.p < k * k);
        e.mac_en    = s.act && (s.p >= 1) && (s.p <= k * k);
        e.mac_first = s.act && (s.p == 1);
        e.mac_last  = s.act && (s.p == k * k);
        e.out_valid = s.act && (s.p == k * k + 1);
        e.out_addr  = s.act ? s.n : 0;
        e.chk_addr  = !s.act || e.rd_en;
        e.img_addr  = 0;
        e.coef_addr = 0;
        if (e.rd_en) begin
            e.img_addr  = (s.n / ow + s.p / k) * w + (s.n % ow) + (s.p % k);
            e.coef_addr = s.p;
        end
        return e;
    endfunction

    mst_t m1 = '{act: 1'b0, dn: 1'b0, n: 0, p: 0};
    mst_t m2 = '{act: 1'b0, dn: 1'b0, n: 0, p: 0};
    int   rel1 = 0;
    int   rel2 = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m1   <= '{act: 1'b0, dn: 1'b0, n: 0, p: 0};
            m2   <= '{act: 1'b0, dn: 1'b0, n: 0, p: 0};
            rel1 <= 0;
            rel2 <= 0;
        end else begin
            m1   <= step(m1, 3, 36, start, out_ready);
            m2   <= step(m2, 1, 16, start2, out_ready2);
            rel1 <= (!m1.act && !m1.dn && start === 1'b1) ? 1 : rel1 + 1;
            rel2 <= (!m2.act && !m2.dn && start2 === 1'b1) ? 1 : rel2 + 1;
        end
    end

    task automatic cmp(string tag, exp_t e, logic bz, logic dn, logic rd, logic me, logic mf,
                       logic ml, logic ov, int ia, int ca, int oa);
        chk({tag, ".busy"}, bz, e.busy);
        chk({tag, ".done"}, dn, e.done);
        chk({tag, ".rd_en"}, rd, e.rd_en);
        chk({tag, ".mac_en"}, me, e.mac_en);
        chk({tag, ".mac_first"}, mf, e.mac_first);
        chk({tag, ".mac_last"}, ml, e.mac_last);
        chk({tag, ".out_valid"}, ov, e.out_valid);
        chk({tag, ".out_addr"}, oa, e.out_addr);
        if (e.chk_addr) begin
            chk({tag, ".img_addr"}, ia, e.img_addr);
            chk({tag, ".coef_addr"}, ca, e.coef_addr);
        end
    endtask

    // Per-frame logs for the literal expectations
    int   addr_q[$], coef_q[$], xfer_q[$];
    int   first_cyc, last_cyc, ov_cyc, ov_addr, ov0_cnt, rise_cnt, rise2_cyc, last_rise_addr;
    int   done_cnt, done_cyc;
    int   done2_cnt, done2_cyc, fl2_cnt, xfer2_cnt;
    logic prev_rd = 1'b0;

    task automatic clear_logs();
        addr_q.delete();
        coef_q.delete();
        xfer_q.delete();
        first_cyc      = -1;
        last_cyc       = -1;
        ov_cyc         = -1;
        ov_addr        = -1;
        ov0_cnt        = 0;
        rise_cnt       = 0;
        rise2_cyc      = -1;
        last_rise_addr = -1;
        done_cnt       = 0;
        done_cyc       = -1;
        done2_cnt      = 0;
        done2_cyc      = -1;
        fl2_cnt        = 0;
        xfer2_cnt      = 0;
    endtask

    // Compare process: DUT outputs against the model on every falling edge.
    initial begin
        exp_t e1, e2;
        forever begin
            @(negedge clk);
            e1 = model_out(8, 3, 6, m1);
            e2 = model_out(4, 1, 4, m2);
            cmp("a", e1, busy, done, rd_en, mac_en, mac_first, mac_last, out_valid,
                int'(img_addr), int'(coef_addr), int'(out_addr));
            cmp("b", e2, busy2, done2, rd_en2, mac_en2, mac_first2, mac_last2, out_valid2,
                int'(img_addr2), int'(coef_addr2), int'(out_addr2));
            if (rd_en && addr_q.size() < 9) begin
                addr_q.push_back(int'(img_addr));
                coef_q.push_back(int'(coef_addr));
            end
            if (rd_en && !prev_rd) begin
                rise_cnt++;
                if (rise_cnt == 2) rise2_cyc = rel1;
                last_rise_addr = int'(img_addr);
            end
            prev_rd = rd_en;
            if (mac_first && first_cyc < 0) first_cyc = rel1;
            if (mac_last && last_cyc < 0) last_cyc = rel1;
            if (out_valid && ov_cyc < 0) begin
                ov_cyc  = rel1;
                ov_addr = int'(out_addr);
            end
            if (out_valid && out_addr == 6'd0) ov0_cnt++;
            if (out_valid && out_ready) xfer_q.push_back(int'(out_addr));
            if (done) begin
                done_cnt++;
                done_cyc = rel1;
            end
            if (done2) begin
                done2_cnt++;
                done2_cyc = rel2;
            end
            if (mac_en2 && mac_first2 && mac_last2) fl2_cnt++;
            if (out_valid2 && out_ready2) xfer2_cnt++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_done(string name, int budget);
        int i = 0;
        while (done_cnt == 0 && i < budget) begin
            tick();
            i++;
        end
        chk({name, "_done_seen"}, int'(done_cnt > 0), 1);
        repeat (2) tick();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    int exp_addr[9] = '{0, 1, 2, 8, 9, 10, 16, 17, 18};

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        out_ready  = 1'b1;
        start2     = 1'b0;
        out_ready2 = 1'b1;
        clear_logs();
        repeat (3) tick();
        chk("reset_busy", busy, 0);
        chk("reset_out_addr", int'(out_addr), 0);
        rst = 1'b0;
        tick();

        // Full frame, out_ready held high
        clear_logs();
        pulse_start();
        wait_done("frame1", 600);
        for (int i = 0; i < 9; i++) begin
            chk($sformatf("f1_img_addr[%0d]", i), (i < addr_q.size()) ? addr_q[i] : -1,
                exp_addr[i]);
            chk($sformatf("f1_coef_addr[%0d]", i), (i < coef_q.size()) ? coef_q[i] : -1, i);
        end
        chk("f1_mac_first_cyc", first_cyc, 2);
        chk("f1_mac_last_cyc", last_cyc, 10);
        chk("f1_out_valid_cyc", ov_cyc, 11);
        chk("f1_out_valid_addr", ov_addr, 0);
        chk("f1_xfer_count", xfer_q.size(), 36);
        for (int i = 0; i < 36; i++) begin
            chk($sformatf("f1_xfer[%0d]", i), (i < xfer_q.size()) ? xfer_q[i] : -1, i);
        end
        chk("f1_last_tap_start", last_rise_addr, 45);
        chk("f1_done_cyc", done_cyc, 397);
        chk("f1_done_count", done_cnt, 1);
        chk("f1_busy_after", busy, 0);

        // Stall the first WRITE for 5 cycles
        clear_logs();
        pulse_start();
        repeat (10) tick();
        out_ready = 1'b0;
        repeat (5) tick();
        out_ready = 1'b1;
        wait_done("frame3", 600);
        chk("f3_valid_hold_cycles", ov0_cnt, 6);
        chk("f3_second_mac_cyc", rise2_cyc, 17);
        chk("f3_done_cyc", done_cyc, 402);

        // start re-pulsed mid-frame and during DONE
        clear_logs();
        pulse_start();
        repeat (49) tick();
        pulse_start();
        repeat (149) tick();
        pulse_start();
        repeat (196) tick();
        pulse_start();
        repeat (20) tick();
        chk("f4_done_count", done_cnt, 1);
        chk("f4_done_cyc", done_cyc, 397);
        chk("f4_xfer_count", xfer_q.size(), 36);
        chk("f4_busy_after", busy, 0);

        // Reset during MAC of output 7, then a fresh frame
        clear_logs();
        pulse_start();
        repeat (79) tick();
        rst = 1'b1;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_rd_en", rd_en, 0);
        chk("rst_img_addr", int'(img_addr), 0);
        chk("rst_coef_addr", int'(coef_addr), 0);
        chk("rst_mac_en", mac_en, 0);
        chk("rst_mac_first", mac_first, 0);
        chk("rst_mac_last", mac_last, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_addr", int'(out_addr), 0);
        tick();
        rst = 1'b0;
        tick();
        clear_logs();
        pulse_start();
        chk("f5_rd_en_cyc1", rd_en, 1);
        chk("f5_img_addr_cyc1", int'(img_addr), 0);
        chk("f5_out_addr_cyc1", int'(out_addr), 0);
        wait_done("frame5", 600);
        chk("f5_first_xfer", (xfer_q.size() > 0) ? xfer_q[0] : -1, 0);
        chk("f5_xfer_count", xfer_q.size(), 36);
        chk("f5_done_cyc", done_cyc, 397);

        // K=1 on a 4x4 image
        clear_logs();
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        for (int i = 0; i < 100 && done2_cnt == 0; i++) tick();
        repeat (3) tick();
        chk("k1_done_count", done2_cnt, 1);
        chk("k1_done_cyc", done2_cyc, 49);
        chk("k1_first_last_same", fl2_cnt, 16);
        chk("k1_xfer_count", xfer2_cnt, 16);
        chk("k1_busy_after", busy2, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
